// File: rtl/vga_monitor_if.sv
// VGA pixel bus as seen at the connector: active-high syncs and a 3-3-3 colour bus.
// The generator side drives it, the monitor only listens.
interface vga_monitor_if;
   logic       hs;
   logic       vs;
   logic [2:0] r;
   logic [2:0] g;
   logic [2:0] b;

   modport master (output hs, vs, r, g, b);
   modport slave  (input  hs, vs, r, g, b);
endinterface

// File: rtl/vga_monitor.sv
// In-system VGA stream monitor: recovers beam position, checks sync timing
// against the configured mode, locks after clean frames and samples one probe pixel.
module vga_monitor #(
   parameter int H_TOTAL     = 1040,
   parameter int H_SYNC      = 120,
   parameter int H_BACK      = 64,
   parameter int H_ACTIVE    = 800,
   parameter int V_TOTAL     = 666,
   parameter int V_SYNC      = 6,
   parameter int V_BACK      = 23,
   parameter int V_ACTIVE    = 600,
   parameter int LOCK_FRAMES = 2
) (
   input  logic          i_clk,
   input  logic          i_rst,
   vga_monitor_if.slave  i_vga,
   input  logic [10:0]   i_probe_x,
   input  logic [10:0]   i_probe_y,
   output logic [10:0]   o_x,
   output logic [10:0]   o_y,
   output logic          o_active,
   output logic          o_locked,
   output logic          o_h_err,
   output logic          o_v_err,
   output logic [15:0]   o_frame_count,
   output logic [8:0]    o_probe_rgb,
   output logic          o_probe_valid
);

   localparam logic [11:0] LP_H_TOTAL   = 12'(H_TOTAL);
   localparam logic [11:0] LP_H_SYNC    = 12'(H_SYNC);
   localparam logic [11:0] LP_V_TOTAL   = 12'(V_TOTAL);
   localparam logic [10:0] LP_V_SYNC_M1 = 11'(V_SYNC - 1);
   localparam logic [11:0] LP_H_START   = 12'(H_SYNC + H_BACK);
   localparam logic [11:0] LP_H_END     = 12'(H_SYNC + H_BACK + H_ACTIVE);
   localparam logic [11:0] LP_V_START   = 12'(V_SYNC + V_BACK);
   localparam logic [11:0] LP_V_END     = 12'(V_SYNC + V_BACK + V_ACTIVE);
   localparam logic [10:0] LP_X_OFS     = 11'(H_SYNC + H_BACK);
   localparam logic [10:0] LP_Y_OFS     = 11'(V_SYNC + V_BACK);
   localparam logic [7:0]  LP_LOCK      = 8'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      S_SEARCH  = 2'd0,
      S_ACQUIRE = 2'd1,
      S_LOCKED  = 2'd2
   } state_t;

   logic        r_hs1, r_vs1, r_hs2, r_vs2;
   logic [8:0]  r_rgb1;
   logic [10:0] r_hcnt, r_vcnt;
   logic        r_hseen, r_vseen;
   state_t      r_state;
   logic [7:0]  r_good;
   logic [15:0] r_frame_count;

   logic        w_hs_rise, w_hs_fall, w_vs_rise, w_vs_fall;
   logic [11:0] w_hcnt_inc, w_vcnt_inc;
   logic [10:0] w_hcnt_n, w_vcnt_n;
   logic        w_h_err, w_v_err, w_err;
   logic        w_hseen_n, w_vseen_n;
   state_t      w_state_n;
   logic [7:0]  w_good_n;
   logic [15:0] w_fc_n;
   logic        w_in_h, w_in_v, w_active_n;
   logic [10:0] w_x_n, w_y_n;
   logic        w_hit;

   assign w_hs_rise  = r_hs1 & ~r_hs2;
   assign w_hs_fall  = ~r_hs1 & r_hs2;
   assign w_vs_rise  = r_vs1 & ~r_vs2;
   assign w_vs_fall  = ~r_vs1 & r_vs2;
   // 12-bit increments so a saturated counter never aliases onto a legal period
   assign w_hcnt_inc = {1'b0, r_hcnt} + 12'd1;
   assign w_vcnt_inc = {1'b0, r_vcnt} + 12'd1;

   // position counters, timing checks and active-window decode for the current sample
   always_comb begin
      w_hcnt_n = r_hcnt;
      w_vcnt_n = r_vcnt;
      if (w_hs_rise) begin
         w_hcnt_n = 11'd0;
      end else if (r_hcnt == 11'h7FF) begin
         w_hcnt_n = r_hcnt;
      end else begin
         w_hcnt_n = w_hcnt_inc[10:0];
      end
      if (w_vs_rise) begin
         w_vcnt_n = 11'd0;
      end else if (w_hs_rise && (r_vcnt != 11'h7FF)) begin
         w_vcnt_n = w_vcnt_inc[10:0];
      end else begin
         w_vcnt_n = r_vcnt;
      end

      w_h_err = r_hseen & ((w_hs_rise & (w_hcnt_inc != LP_H_TOTAL)) |
                           (w_hs_fall & (w_hcnt_inc != LP_H_SYNC)));
      w_v_err = r_vseen & ((w_vs_rise & (w_vcnt_inc != LP_V_TOTAL)) |
                           (w_vs_fall & (r_vcnt != LP_V_SYNC_M1)));
      w_err   = w_h_err | w_v_err;

      w_hseen_n = w_err ? 1'b0 : (r_hseen | w_hs_rise);
      w_vseen_n = w_err ? 1'b0 : (r_vseen | w_vs_rise);

      w_in_h     = ({1'b0, w_hcnt_n} >= LP_H_START) && ({1'b0, w_hcnt_n} < LP_H_END);
      w_in_v     = ({1'b0, w_vcnt_n} >= LP_V_START) && ({1'b0, w_vcnt_n} < LP_V_END);
      w_active_n = (w_state_n == S_LOCKED) & w_in_h & w_in_v;
      if (w_active_n) begin
         w_x_n = w_hcnt_n - LP_X_OFS;
         w_y_n = w_vcnt_n - LP_Y_OFS;
      end else begin
         w_x_n = 11'd0;
         w_y_n = 11'd0;
      end
      w_hit = w_active_n & (w_x_n == i_probe_x) & (w_y_n == i_probe_y);
   end

   // lock state machine; an error always wins over a frame increment
   always_comb begin
      w_state_n = r_state;
      w_good_n  = r_good;
      w_fc_n    = r_frame_count;
      case (r_state)
         S_SEARCH: begin
            if (!w_err && w_vs_rise) begin
               w_state_n = S_ACQUIRE;
               w_good_n  = 8'd0;
            end else begin
               w_state_n = S_SEARCH;
            end
         end
         S_ACQUIRE: begin
            if (w_err) begin
               w_state_n = S_SEARCH;
            end else if (w_vs_rise) begin
               w_good_n = r_good + 8'd1;
               if (w_good_n == LP_LOCK) begin
                  w_state_n = S_LOCKED;
               end else begin
                  w_state_n = S_ACQUIRE;
               end
            end else begin
               w_state_n = S_ACQUIRE;
            end
         end
         S_LOCKED: begin
            if (w_err) begin
               w_state_n = S_SEARCH;
            end else if (w_vs_rise) begin
               w_fc_n = r_frame_count + 16'd1;
            end else begin
               w_state_n = S_LOCKED;
            end
         end
         default: begin
            w_state_n = S_SEARCH;
         end
      endcase
   end

   // input stage, counters, state and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_hs1         <= 1'b0;
         r_vs1         <= 1'b0;
         r_hs2         <= 1'b0;
         r_vs2         <= 1'b0;
         r_rgb1        <= 9'd0;
         r_hcnt        <= 11'd0;
         r_vcnt        <= 11'd0;
         r_hseen       <= 1'b0;
         r_vseen       <= 1'b0;
         r_state       <= S_SEARCH;
         r_good        <= 8'd0;
         r_frame_count <= 16'd0;
         o_x           <= 11'd0;
         o_y           <= 11'd0;
         o_active      <= 1'b0;
         o_locked      <= 1'b0;
         o_h_err       <= 1'b0;
         o_v_err       <= 1'b0;
         o_probe_rgb   <= 9'd0;
         o_probe_valid <= 1'b0;
      end else begin
         r_hs1         <= i_vga.hs;
         r_vs1         <= i_vga.vs;
         r_hs2         <= r_hs1;
         r_vs2         <= r_vs1;
         r_rgb1        <= {i_vga.r, i_vga.g, i_vga.b};
         r_hcnt        <= w_hcnt_n;
         r_vcnt        <= w_vcnt_n;
         r_hseen       <= w_hseen_n;
         r_vseen       <= w_vseen_n;
         r_state       <= w_state_n;
         r_good        <= w_good_n;
         r_frame_count <= w_fc_n;
         o_x           <= w_x_n;
         o_y           <= w_y_n;
         o_active      <= w_active_n;
         o_locked      <= (w_state_n == S_LOCKED);
         o_h_err       <= w_h_err;
         o_v_err       <= w_v_err;
         o_probe_valid <= w_hit;
         if (w_hit) begin
            o_probe_rgb <= r_rgb1;
         end
      end
   end

   assign o_frame_count = r_frame_count;

endmodule
